// File: rtl/uart_host_ctrl_pkg.sv
// Shared types and constants for the UART host controller: FSM state encoding,
// UART register addresses, register bit positions and the TX word builder.
package uart_host_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX_CLR,
      TX_WR,
      TX_WAIT_BUSY,
      TX_WAIT_DONE
   } ctrlState_e;

   localparam logic UART_ADDR_TX = 1'b0;
   localparam logic UART_ADDR_RX = 1'b1;

   localparam int TX_START_BIT = 0;
   localparam int TX_BUSY_BIT  = 1;
   localparam int TX_DATA_LSB  = 24;
   localparam int RX_BUSY_BIT  = 8;
   localparam int RX_FIN_BIT   = 9;

   // TX register image: byte in the top lane, busy written as 0, start set.
   function automatic logic [31:0] txWord(input logic [7:0] b);
      logic [31:0] w;
      w = '0;
      w[TX_DATA_LSB +: 8] = b;
      w[TX_START_BIT]     = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/uart_host_ctrl_if.sv
// Bundle of requester, consumer and UART register-port signals around the
// host controller. master = the controller, slave = everything around it.
interface uart_host_ctrl_if;

   logic        req0_valid;
   logic [7:0]  req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [7:0]  req1_data;
   logic        req1_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        uart_wrtEn;
   logic        uart_addr;
   logic [31:0] uart_txdata;
   logic [31:0] uart_readreg;
   logic        tx_done;
   logic        err_timeout;

   modport master (
      input  req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_readreg,
      output req0_ready, req1_ready, rx_valid, rx_data,
      output uart_wrtEn, uart_addr, uart_txdata, tx_done, err_timeout
   );

   modport slave (
      output req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_readreg,
      input  req0_ready, req1_ready, rx_valid, rx_data,
      input  uart_wrtEn, uart_addr, uart_txdata, tx_done, err_timeout
   );

endinterface

// File: rtl/uart_host_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie;
// after a grant it moves to the other requester. Grants are combinational and
// only issued while en is high, so a grant is always an acceptance.
module uart_rr_arb2 (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic ptr;

   // Favoured requester first, the other one only if the favoured one is idle.
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (req[ptr]) begin
            grant[ptr] = 1'b1;
         end else if (req[~ptr]) begin
            grant[~ptr] = 1'b1;
         end
      end
   end

   // Hand the tie-break to whichever requester was not just served.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr <= 1'b0;
      end else if (grant[0]) begin
         ptr <= 1'b1;
      end else if (grant[1]) begin
         ptr <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_host_ctrl.sv
// UART host controller: shares the UART TX register between two byte
// requesters and drains received bytes into a one-entry holding register.
// Build option UART_HOST_CTRL_RX_EN: when defined, IDLE polls the RX register
// and the RX_CLR state plus holding register exist; otherwise IDLE sits on the
// TX address and only arbitrates TX, with rx_valid tied low.
//
// state        | meaning
// IDLE         | poll RX finish flag (RX build), else arbitrate TX requesters
// RX_CLR       | write 0 to RX register to clear its finish flag
// TX_WR        | write byte with start bit to TX register
// TX_WAIT_BUSY | wait for the UART to report busy (timed)
// TX_WAIT_DONE | wait for busy to fall, then pulse tx_done (timed)
module uart_host_ctrl
   import uart_host_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic              clk,
   input logic              n_rst,
   uart_host_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_HOST_CTRL_RX_EN
   localparam logic IDLE_ADDR = UART_ADDR_RX;
`else
   localparam logic IDLE_ADDR = UART_ADDR_TX;
`endif

   ctrlState_e       state;
   logic [CNT_W-1:0] waitCnt;
   logic             wrtEnQ;
   logic             addrQ;
   logic [31:0]      txDataQ;
   logic             txDoneQ;
   logic             errQ;
   logic             rxTake;
   logic             arbEn;
   logic [1:0]       grant;
   logic             unusedSink;

   // Only some ReadReg bits matter, and rx_ready is ignored without RX.
   assign unusedSink = ^{bus.uart_readreg, bus.rx_ready};

`ifdef UART_HOST_CTRL_RX_EN
   logic       rxValidQ;
   logic [7:0] rxDataQ;

   // Capture wins over TX in IDLE; a full holding register leaves the byte in the UART.
   assign rxTake = (state == IDLE) && bus.uart_readreg[RX_FIN_BIT] && !rxValidQ;

   // Holding register: fill on capture, empty on consumer pop.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rxValidQ <= 1'b0;
         rxDataQ  <= '0;
      end else if (rxTake) begin
         rxValidQ <= 1'b1;
         rxDataQ  <= bus.uart_readreg[7:0];
      end else if (rxValidQ && bus.rx_ready) begin
         rxValidQ <= 1'b0;
      end
   end

   assign bus.rx_valid = rxValidQ;
   assign bus.rx_data  = rxDataQ;
`else
   assign rxTake       = 1'b0;
   assign bus.rx_valid = 1'b0;
   assign bus.rx_data  = '0;
`endif

   assign arbEn = (state == IDLE) && !rxTake;

   uart_rr_arb2 u_arb (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (arbEn),
      .req   ({bus.req1_valid, bus.req0_valid}),
      .grant (grant)
   );

   assign bus.req0_ready  = grant[0];
   assign bus.req1_ready  = grant[1];
   assign bus.uart_wrtEn  = wrtEnQ;
   assign bus.uart_addr   = addrQ;
   assign bus.uart_txdata = txDataQ;
   assign bus.tx_done     = txDoneQ;
   assign bus.err_timeout = errQ;

   // Sequencer; UART strobes are set on the edge that enters the state they belong to.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         waitCnt <= '0;
         wrtEnQ  <= 1'b0;
         addrQ   <= UART_ADDR_RX;
         txDataQ <= '0;
         txDoneQ <= 1'b0;
         errQ    <= 1'b0;
      end else begin
         wrtEnQ  <= 1'b0;
         txDoneQ <= 1'b0;
         case (state)
            IDLE: begin
               addrQ <= IDLE_ADDR;
               if (rxTake) begin
                  state   <= RX_CLR;
                  wrtEnQ  <= 1'b1;
                  addrQ   <= UART_ADDR_RX;
                  txDataQ <= '0;
               end else if (|grant) begin
                  state   <= TX_WR;
                  wrtEnQ  <= 1'b1;
                  addrQ   <= UART_ADDR_TX;
                  txDataQ <= txWord(grant[1] ? bus.req1_data : bus.req0_data);
               end
            end
`ifdef UART_HOST_CTRL_RX_EN
            RX_CLR: begin
               state <= IDLE;
               addrQ <= IDLE_ADDR;
            end
`endif
            TX_WR: begin
               state   <= TX_WAIT_BUSY;
               addrQ   <= UART_ADDR_TX;
               waitCnt <= '0;
            end
            TX_WAIT_BUSY: begin
               if (bus.uart_readreg[TX_BUSY_BIT]) begin
                  state   <= TX_WAIT_DONE;
                  waitCnt <= '0;
               end else if (waitCnt == CNT_LAST) begin
                  state <= IDLE;
                  addrQ <= IDLE_ADDR;
                  errQ  <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + CNT_W'(1);
               end
            end
            TX_WAIT_DONE: begin
               if (!bus.uart_readreg[TX_BUSY_BIT]) begin
                  state   <= IDLE;
                  addrQ   <= IDLE_ADDR;
                  txDoneQ <= 1'b1;
               end else if (waitCnt == CNT_LAST) begin
                  state <= IDLE;
                  addrQ <= IDLE_ADDR;
                  errQ  <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               addrQ <= IDLE_ADDR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: a small UART register model, directed requester and
// RX stimulus, and a forked monitor that checks UART writes, grants, RX pops and
// tx_done pulses against expectation queues. A second instance with a short
// timeout exercises the abort path. RX cases are built only with UART_HOST_CTRL_RX_EN.
`timescale 1ns/1ps
module tb_uart_host_ctrl;

   logic clk = 1'b0;
   logic n_rst;

   uart_host_ctrl_if bus ();
   uart_host_ctrl_if busTo ();

   uart_host_ctrl dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   uart_host_ctrl #(.TIMEOUT_CYCLES(16)) dutTo (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (busTo)
   );

   always #5 clk = ~clk;

   int nVec = 0;
   int nErr = 0;

   logic [32:0] expWr[$];
   int          expGrant[$];
   logic [7:0]  expRx[$];
   int          expDone = 0;
   int          doneCount = 0;
   int          doneHigh = 0;

   // UART model: TX busy rises 3 cycles after a start write and stays high 20 cycles;
   // RX bytes wait in rxInj until a write to the RX register clears the finish flag.
   logic [7:0] rxInj [8];
   int         rxInjCount = 0;
   int         rxHead = 0;
   int         txCnt = 0;
   logic       txBusy;

   assign txBusy = (txCnt >= 4);

   always_comb begin
      bus.uart_readreg = '0;
      if (bus.uart_addr == 1'b0) begin
         bus.uart_readreg[1] = txBusy;
      end else if (rxHead < rxInjCount) begin
         bus.uart_readreg[9]   = 1'b1;
         bus.uart_readreg[7:0] = rxInj[rxHead[2:0]];
      end
   end

   always @(posedge clk) begin
      if (bus.uart_wrtEn && bus.uart_addr == 1'b0 && bus.uart_txdata[0]) txCnt <= 1;
      else if (txCnt == 23) txCnt <= 0;
      else if (txCnt != 0) txCnt <= txCnt + 1;
      if (bus.uart_wrtEn && bus.uart_addr == 1'b1) rxHead <= rxHead + 1;
   end

   assign busTo.uart_readreg = 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      nErr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic monitor();
      logic prevDone = 1'b0;
      logic prevRxValid = 1'b0;
      logic prevPop = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.req0_ready || bus.req1_ready) begin
            check("one_ready", 64'(bus.req0_ready & bus.req1_ready), 0);
            if (expGrant.size() == 0) fail("grant_unexpected", 64'(bus.req1_ready), 64'hff);
            else check("grant_id", 64'(bus.req1_ready), 64'(expGrant.pop_front()));
         end
         if (bus.uart_wrtEn) begin
            if (expWr.size() == 0) fail("write_unexpected", {bus.uart_addr, bus.uart_txdata}, 64'hff);
            else check("uart_write", {bus.uart_addr, bus.uart_txdata}, 64'(expWr.pop_front()));
            if (bus.uart_addr == 1'b1) check("clr_with_capture", {bus.rx_valid, prevRxValid}, 2'b10);
         end
         if (prevPop) check("rx_valid_drop", 64'(bus.rx_valid), 0);
         if (bus.rx_valid && bus.rx_ready) begin
            if (expRx.size() == 0) fail("rx_unexpected", 64'(bus.rx_data), 64'hfff);
            else check("rx_data", 64'(bus.rx_data), 64'(expRx.pop_front()));
         end
         prevPop = bus.rx_valid && bus.rx_ready;
         if (bus.tx_done) doneHigh++;
         if (bus.tx_done && !prevDone) doneCount++;
         prevDone    = bus.tx_done;
         prevRxValid = bus.rx_valid;
      end
   endtask

   task automatic sendByte(input int id, input logic [7:0] b);
      bit got = 1'b0;
      if (id == 0) begin
         bus.req0_data  = b;
         bus.req0_valid = 1'b1;
      end else begin
         bus.req1_data  = b;
         bus.req1_valid = 1'b1;
      end
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = (id == 0) ? bus.req0_ready : bus.req1_ready;
      end
      if (!got) fail("req_ready_timeout", 64'(id), 64'h1);
      @(posedge clk);
      #1;
      if (id == 0) bus.req0_valid = 1'b0;
      else bus.req1_valid = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      n_rst = 1'b0;
      @(negedge clk);
      check("reset_outputs",
            {bus.uart_wrtEn, bus.uart_addr, bus.uart_txdata, bus.tx_done, bus.err_timeout,
             bus.req0_ready, bus.req1_ready, bus.rx_valid, bus.rx_data},
            {1'b0, 1'b1, 45'h0});
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic waitDone();
      for (int i = 0; i < 400 && doneCount < expDone; i++) @(posedge clk);
      #1;
      check("tx_done_count_reached", 64'(doneCount), 64'(expDone));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      n_rst          = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_data  = '0;
      bus.rx_ready   = 1'b0;
      busTo.req0_valid = 1'b0;
      busTo.req0_data  = '0;
      busTo.req1_valid = 1'b0;
      busTo.req1_data  = '0;
      busTo.rx_ready   = 1'b0;
      for (int i = 0; i < 8; i++) rxInj[i] = '0;

      fork
         monitor();
      join_none

      doReset();

      // single requester 0 byte
      expGrant.push_back(0);
      expWr.push_back({1'b0, 32'h4100_0001});
      expDone++;
      sendByte(0, 8'h41);
      waitDone();

`ifdef UART_HOST_CTRL_RX_EN
      // two RX bytes, consumer stalled: second one must stay in the UART
      tick(1);
      rxInj[rxInjCount[2:0]] = 8'h3C;
      rxInjCount++;
      rxInj[rxInjCount[2:0]] = 8'h7E;
      rxInjCount++;
      expWr.push_back({1'b1, 32'h0});
      expWr.push_back({1'b1, 32'h0});
      expRx.push_back(8'h3C);
      expRx.push_back(8'h7E);
      tick(8);
      check("rx_hold_valid", 64'(bus.rx_valid), 1);
      check("rx_hold_data", 64'(bus.rx_data), 64'h3C);
      check("rx_pending_in_uart", 64'(rxHead), 1);
      bus.rx_ready = 1'b1;
      tick(8);
      bus.rx_ready = 1'b0;
      check("rx_second_cleared", 64'(rxHead), 2);

      // RX finish and requester 1 in the same IDLE cycle: RX clear goes first
      rxInj[rxInjCount[2:0]] = 8'h11;
      rxInjCount++;
      expWr.push_back({1'b1, 32'h0});
      expRx.push_back(8'h11);
`endif
      expGrant.push_back(1);
      expWr.push_back({1'b0, 32'hB200_0001});
      expDone++;
      sendByte(1, 8'hB2);
      waitDone();
      bus.rx_ready = 1'b1;
      tick(4);
      bus.rx_ready = 1'b0;

      // both requesters valid together, twice, from a fresh pointer
      doReset();
      expGrant.push_back(0);
      expGrant.push_back(1);
      expGrant.push_back(0);
      expGrant.push_back(1);
      expWr.push_back({1'b0, 32'h5500_0001});
      expWr.push_back({1'b0, 32'hAA00_0001});
      expWr.push_back({1'b0, 32'h5500_0001});
      expWr.push_back({1'b0, 32'hAA00_0001});
      expDone += 4;
      for (int r = 0; r < 2; r++) begin
         fork
            sendByte(0, 8'h55);
            sendByte(1, 8'hAA);
         join
      end
      waitDone();

      // reset while waiting for busy to fall; in-flight byte is lost
      expGrant.push_back(0);
      expWr.push_back({1'b0, 32'h6600_0001});
      sendByte(0, 8'h66);
      for (int i = 0; i < 50 && !txBusy; i++) @(posedge clk);
      check("model_busy_before_reset", 64'(txBusy), 1);
      tick(3);
      doReset();
      check("err_after_reset", 64'(bus.err_timeout), 0);
      expGrant.push_back(0);
      expWr.push_back({1'b0, 32'h7700_0001});
      expDone++;
      sendByte(0, 8'h77);
      waitDone();

      tick(40);
      check("write_queue_drained", 64'(expWr.size()), 0);
      check("grant_queue_drained", 64'(expGrant.size()), 0);
      check("rx_queue_drained", 64'(expRx.size()), 0);
      check("tx_done_pulses", 64'(doneCount), 64'(expDone));
      check("tx_done_high_cycles", 64'(doneHigh), 64'(expDone));
      check("err_clear_main", 64'(bus.err_timeout), 0);

      // timeout instance: busy never rises, abort after 16 wait cycles
      begin
         bit seenWr = 1'b0;
         bit seenDone = 1'b0;
         busTo.req0_data  = 8'h5A;
         busTo.req0_valid = 1'b1;
         for (int i = 0; i < 20 && !seenWr; i++) begin
            @(negedge clk);
            seenWr = busTo.uart_wrtEn;
         end
         busTo.req0_valid = 1'b0;
         if (!seenWr) fail("to_write_timeout", 0, 1);
         check("to_write_word", {busTo.uart_addr, busTo.uart_txdata}, {1'b0, 32'h5A00_0001});
         for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (busTo.tx_done) seenDone = 1'b1;
            if (k == 16) check("to_err_before_limit", 64'(busTo.err_timeout), 0);
            if (k == 17) check("to_err_at_limit", 64'(busTo.err_timeout), 1);
         end
         check("to_err_sticky", 64'(busTo.err_timeout), 1);
         check("to_no_tx_done", 64'(seenDone), 0);
      end
      check("err_clear_main_end", 64'(bus.err_timeout), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
